// File: rtl/bin_to_bcd_digits_if.sv
// Request/result bundle for the binary-to-BCD converter.
// master drives the request; slave is the converter.
interface bin_to_bcd_digits_if #(
    parameter int BIN_WIDTH  = 10,
    parameter int NUM_DIGITS = 3
);
    logic                    start;
    logic [BIN_WIDTH-1:0]    bin_in;
    logic                    busy;
    logic                    done;
    logic                    overflow;
    logic [4*NUM_DIGITS-1:0] digits;

    modport master (
        output start, bin_in,
        input  busy, done, overflow, digits
    );

    modport slave (
        input  start, bin_in,
        output busy, done, overflow, digits
    );
endinterface

// File: rtl/bin_to_bcd_digits.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one iteration per input bit.
// Results saturate to all nines with overflow set when the value needs more than NUM_DIGITS digits.
module bin_to_bcd_digits #(
    parameter int BIN_WIDTH  = 10,
    parameter int NUM_DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bin_to_bcd_digits_if.slave   bus
);
    localparam int ACC_W = 4 * (NUM_DIGITS + 1);
    localparam int DIG_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t             state_r;
    logic [ACC_W-1:0]   acc_r;
    logic [BIN_WIDTH-1:0] bin_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               sticky_r;
    logic               busy_r;
    logic               done_r;
    logic               overflow_r;
    logic [DIG_W-1:0]   digits_r;

    logic [ACC_W-1:0]   acc_adj_s;
    logic [ACC_W-1:0]   acc_shift_s;
    logic               carry_s;
    logic               ovf_s;

    function automatic logic [ACC_W-1:0] add3_nibbles(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] res;
        res = acc;
        for (int i = 0; i < NUM_DIGITS + 1; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = acc[4*i +: 4];
            end
        end
        return res;
    endfunction

    function automatic logic [DIG_W-1:0] all_nines();
        logic [DIG_W-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            res[4*i +: 4] = 4'h9;
        end
        return res;
    endfunction

    // One double-dabble step; a bit leaving the guard digit marks overflow.
    always_comb begin
        acc_adj_s   = add3_nibbles(acc_r);
        acc_shift_s = {acc_adj_s[ACC_W-2:0], bin_r[BIN_WIDTH-1]};
        carry_s     = acc_adj_s[ACC_W-1];
        ovf_s       = sticky_r | carry_s | (acc_shift_s[ACC_W-1 -: 4] != 4'd0);
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            acc_r      <= '0;
            bin_r      <= '0;
            cnt_r      <= '0;
            sticky_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            digits_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_FIN: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r  <= ST_CONV;
                        busy_r   <= 1'b1;
                        bin_r    <= bus.bin_in;
                        acc_r    <= '0;
                        sticky_r <= 1'b0;
                        cnt_r    <= CNT_W'(BIN_WIDTH);
                    end else begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                    end
                end
                ST_CONV: begin
                    acc_r    <= acc_shift_s;
                    bin_r    <= bin_r << 1;
                    sticky_r <= sticky_r | carry_s;
                    cnt_r    <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        // Results only move here, so the display holds steady during CONV.
                        state_r    <= ST_FIN;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        overflow_r <= ovf_s;
                        digits_r   <= ovf_s ? all_nines() : acc_shift_s[DIG_W-1:0];
                    end else begin
                        state_r    <= ST_CONV;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overflow = overflow_r;
    assign bus.digits   = digits_r;
endmodule
